// File: rtl/fragment_stamp_gen.sv
// fragment_stamp_gen
//   Walks a triangle bounding box in horizontal stamps of LANES pixels. Three
//   fixed-point edge functions are stepped incrementally, and each stamp with
//   at least one covered pixel is pushed into a small output FIFO.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   start, abort               begin traversal (IDLE only) / cancel and flush
//   xmin..ymax                 inclusive bounding box (unsigned, CW bits)
//   l*_dx, l*_dy, w*_00        edge row decrement, pixel increment, origin value
//   out_valid/out_ready        FIFO head handshake
//   out_x, out_y, out_mask     lane-0 coordinates and per-lane coverage
//   out_w0..out_w2             edge values at lane 0
//   busy, done                 traversal active / one-cycle completion pulse
module fragment_stamp_gen #(
  parameter int W       = 32,
  parameter int LANES   = 4,
  parameter int LG_FIFO = 3,
  parameter int CW      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [CW-1:0]     xmin,
  input  logic [CW-1:0]     xmax,
  input  logic [CW-1:0]     ymin,
  input  logic [CW-1:0]     ymax,
  input  logic [W-1:0]      l0_dx,
  input  logic [W-1:0]      l1_dx,
  input  logic [W-1:0]      l2_dx,
  input  logic [W-1:0]      l0_dy,
  input  logic [W-1:0]      l1_dy,
  input  logic [W-1:0]      l2_dy,
  input  logic [W-1:0]      w0_00,
  input  logic [W-1:0]      w1_00,
  input  logic [W-1:0]      w2_00,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CW-1:0]     out_x,
  output logic [CW-1:0]     out_y,
  output logic [LANES-1:0]  out_mask,
  output logic [W-1:0]      out_w0,
  output logic [W-1:0]      out_w1,
  output logic [W-1:0]      out_w2,
  output logic              busy,
  output logic              done
);

  localparam int DEPTH = 1 << LG_FIFO;
  localparam int FW    = 2 * CW + LANES + 3 * W;

  typedef enum logic [2:0] {IDLE, SETUP, GEN, DRAIN, EMPTY_DONE} state_t;

  state_t          state_reg;
  logic            done_reg;

  // Latched triangle parameters
  logic [CW-1:0]   xmin_reg, xmax_reg, ymin_reg, ymax_reg;
  logic [W-1:0]    dx_reg  [3];
  logic [W-1:0]    dy_reg  [3];
  logic [W-1:0]    w00_reg [3];

  // Traversal state
  logic [W-1:0]    off_reg   [3][LANES];
  logic [W-1:0]    step_reg  [3];
  logic [W-1:0]    row_reg   [3];
  logic [W-1:0]    chunk_reg [3];
  logic [CW-1:0]   x_reg, y_reg;

  // FIFO
  logic [FW-1:0]   mem [DEPTH];
  logic [LG_FIFO:0] wr_ptr_reg, rd_ptr_reg;
  logic            fifo_empty, fifo_full, pop, push, gen_go, kill;
  logic [LANES-1:0] mask;
  logic [CW:0]     next_x_wide;
  logic [FW-1:0]   push_data, head;

  // Per-lane coverage. The lane x coordinate is widened by one bit so a box
  // ending near the top of the coordinate range cannot wrap lanes back in.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [W-1:0] v0, v1, v2;
      logic [CW:0]  lx;
      assign v0 = chunk_reg[0] + off_reg[0][gi];
      assign v1 = chunk_reg[1] + off_reg[1][gi];
      assign v2 = chunk_reg[2] + off_reg[2][gi];
      assign lx = {1'b0, x_reg} + (CW+1)'(gi);
      assign mask[gi] = ~v0[W-1] & ~v1[W-1] & ~v2[W-1] & (lx <= {1'b0, xmax_reg});
    end
  endgenerate

  assign kill        = abort && (state_reg != IDLE);
  assign fifo_empty  = (wr_ptr_reg == rd_ptr_reg);
  // Same index with differing wrap bits means the writer is a full lap ahead
  assign fifo_full   = (wr_ptr_reg[LG_FIFO] != rd_ptr_reg[LG_FIFO]) &&
                       (wr_ptr_reg[LG_FIFO-1:0] == rd_ptr_reg[LG_FIFO-1:0]);
  assign pop         = !fifo_empty && out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO only stalls GEN
  // when the consumer is not taking the head.
  assign gen_go      = (state_reg == GEN) && !abort && (!fifo_full || pop);
  assign push        = gen_go && (mask != '0);
  assign next_x_wide = {1'b0, x_reg} + (CW+1)'(LANES);
  assign push_data   = {x_reg, y_reg, mask, chunk_reg[0], chunk_reg[1], chunk_reg[2]};

  assign head      = mem[rd_ptr_reg[LG_FIFO-1:0]];
  assign out_valid = !fifo_empty;
  assign {out_x, out_y, out_mask, out_w0, out_w1, out_w2} = head;
  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg[LG_FIFO-1:0]] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst || kill) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (kill) begin
        state_reg <= IDLE;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start) begin
              xmin_reg   <= xmin;
              xmax_reg   <= xmax;
              ymin_reg   <= ymin;
              ymax_reg   <= ymax;
              dx_reg[0]  <= l0_dx;
              dx_reg[1]  <= l1_dx;
              dx_reg[2]  <= l2_dx;
              dy_reg[0]  <= l0_dy;
              dy_reg[1]  <= l1_dy;
              dy_reg[2]  <= l2_dy;
              w00_reg[0] <= w0_00;
              w00_reg[1] <= w1_00;
              w00_reg[2] <= w2_00;
              state_reg  <= ((xmin > xmax) || (ymin > ymax)) ? EMPTY_DONE : SETUP;
            end
          end
          SETUP: begin
            for (int e = 0; e < 3; e++) begin
              for (int k = 0; k < LANES; k++) off_reg[e][k] <= dy_reg[e] * W'(k);
              step_reg[e]  <= dy_reg[e] * W'(LANES);
              row_reg[e]   <= w00_reg[e];
              chunk_reg[e] <= w00_reg[e];
            end
            x_reg     <= xmin_reg;
            y_reg     <= ymin_reg;
            state_reg <= GEN;
          end
          GEN: begin
            if (gen_go) begin
              if (next_x_wide <= {1'b0, xmax_reg}) begin
                x_reg <= next_x_wide[CW-1:0];
                for (int e = 0; e < 3; e++) chunk_reg[e] <= chunk_reg[e] + step_reg[e];
              end else if (y_reg == ymax_reg) begin
                state_reg <= DRAIN;
              end else begin
                y_reg <= y_reg + 1'b1;
                x_reg <= xmin_reg;
                for (int e = 0; e < 3; e++) begin
                  row_reg[e]   <= row_reg[e] - dx_reg[e];
                  chunk_reg[e] <= row_reg[e] - dx_reg[e];
                end
              end
            end
          end
          DRAIN: begin
            if (fifo_empty) begin
              done_reg  <= 1'b1;
              state_reg <= IDLE;
            end
          end
          EMPTY_DONE: begin
            done_reg  <= 1'b1;
            state_reg <= IDLE;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule
